des_tx_serializer: RTL
======================

# des_tx_serializer

Downstream stage of the DES FSMD core. Captures the 64-bit ciphertext `enc_msg` when the core signals `done`, then emits it as eight bytes, most significant first, over a valid/ready byte handshake toward the UART transmitter. Buffers exactly one block. Flags, but never corrupts, a block that arrives while the previous one is still being sent.

## Interface
Parameters:
- `GAP_CYCLES`, default 0: idle cycles inserted between consecutive bytes of one block, range 0..255.

Ports:
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enc_msg`  in  64 (`[64:1]`): ciphertext from the FSMD; sampled only on the capture edge.
- `done`  in  1: FSMD completion flag, level or pulse.
- `byte_out`  out  8 (`[8:1]`): current byte.
- `byte_valid`  out  1: `byte_out` holds a byte to transfer.
- `byte_ready`  in  1: consumer accepts the byte.
- `busy`  out  1: a block is held or in transfer.
- `overrun`  out  1: sticky; a block was dropped.

## Operation
- Reset (`rst`=0, async): state IDLE, `byte_out`=8'h00, `byte_valid`=0, `busy`=0, `overrun`=0, `done_q`=0, byte index=0, gap counter=0, shift register=0.
- Edge detect: `done_q` registers `done` every cycle. A capture event is `done`=1 && `done_q`=0. A `done` held high for many cycles produces one event.
- States:
  - IDLE -> SEND on a capture event. Load the shift register with `enc_msg`, set `byte_out`=`enc_msg[64:57]`, `byte_valid`=1, index=0.
  - SEND: `byte_valid` stays 1 and `byte_out` stays stable until a transfer occurs. A transfer is `byte_valid` && `byte_ready` at a clock edge.
    - On a transfer with index<7: index+1, shift left 8.
    - If `GAP_CYCLES`=0, present the next byte on the same edge, with `byte_valid` staying 1.
    - If `GAP_CYCLES`>0, drop `byte_valid` and go to GAP.
    - On a transfer with index=7: `byte_valid`=0, go to IDLE.
  - GAP: count `GAP_CYCLES` cycles with `byte_valid`=0, then present the next byte, set `byte_valid`=1, and return to SEND.
- `busy`=1 in SEND and GAP, 0 in IDLE.
- Byte order: `enc_msg[64:57]`, `[56:49]`, … `[8:1]`.
- Overrun: a capture event while the state is not IDLE sets `overrun`=1. That includes the edge on which the last byte transfers. The new block is discarded and the current block continues unaffected. `overrun` clears only on reset.
- `byte_ready` while `byte_valid`=0 is ignored.

## Timing
- Capture latency: `done` rises before edge N; at edge N the block is captured and `byte_valid`=1 is visible after edge N.
- With `byte_ready` held 1 and `GAP_CYCLES`=0, the eight transfers occur at edges N+1..N+8. `byte_valid` falls and `busy` falls after edge N+8.
- Per byte with `GAP_CYCLES`=G and `byte_ready` held 1: 1+G cycles. The block takes 8+7G cycles, with no gap after the last byte.
- Earliest new capture event: edge N+9 for G=0. The earliest accepted `done` rise is after `busy` falls.
- Backpressure: `byte_out` and `byte_valid` are held indefinitely while `byte_ready`=0. There is no timeout.
- Reset mid-block: outputs return to reset values immediately. The partial block is lost, and no byte is re-sent after reset release.

## Test plan
- Basic: `enc_msg`=64'h0123456789ABCDEF, one-cycle `done`, `byte_ready`=1 -> bytes 01,23,45,67,89,AB,CD,EF at eight consecutive edges. `busy` is high for 8 cycles, `overrun` stays 0.
- Backpressure: same block, `byte_ready` toggled 1,0,0,1,… pseudo-randomly -> identical byte sequence. `byte_out` is stable whenever `byte_valid`=1 and `byte_ready`=0. No byte is duplicated or skipped.
- Held done: `done` high for 20 cycles with `enc_msg`=64'hFFFF0000AAAA5555 -> exactly one block FF,FF,00,00,AA,AA,55,55 and `overrun`=0.
- Overrun: second `done` rise (`enc_msg`=64'h1111111111111111) while the third byte of block 64'h0123456789ABCDEF is pending -> first block completes intact, 11h is never output, `overrun`=1 until reset.
- Gap: `GAP_CYCLES`=3, `byte_ready`=1 -> each byte's `byte_valid` high 1 cycle then low 3 cycles. Block completes in 29 cycles.
- Reset mid-block: assert `rst`=0 after the second transfer -> `byte_valid`, `busy`, `overrun` go 0 without waiting for a clock edge. After release, a new block 64'h8877665544332211 is sent correctly from 88h.

Source files
------------

// File: rtl/des_tx_serializer.sv
// des_tx_serializer: captures a 64-bit DES block on a rising done and
// streams it out MSB byte first over a valid/ready byte handshake.
module des_tx_serializer #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:1] enc_msg,
    input  logic        done,
    output logic [8:1]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        overrun
);

    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [7:0] GAP_LAST =
        HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t      state, state_d;
    logic        done_q;
    logic [64:1] shreg, shreg_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  gap_cnt, gap_d;
    logic        valid_d;
    logic        ovr_d;
    logic        capture;
    logic        xfer;

    assign capture  = done & ~done_q;
    assign xfer     = byte_valid & byte_ready;
    assign byte_out = shreg[64:57];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            shreg      <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            done_q     <= done;
            shreg      <= shreg_d;
            idx        <= idx_d;
            gap_cnt    <= gap_d;
            byte_valid <= valid_d;
            overrun    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        idx_d   = idx;
        gap_d   = gap_cnt;
        valid_d = byte_valid;
        ovr_d   = overrun;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    shreg_d = enc_msg;
                    idx_d   = 3'd0;
                    valid_d = 1'b1;
                end
            end
            SEND: begin
                // A block arriving mid-transfer is flagged, never loaded.
                if (capture) ovr_d = 1'b1;
                if (xfer) begin
                    if (idx == 3'd7) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 3'd1;
                        shreg_d = {shreg[56:1], 8'h00};
                        if (HAS_GAP) begin
                            valid_d = 1'b0;
                            gap_d   = 8'd0;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (capture) ovr_d = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule
